// File: rtl/dm_access_ctrl_if.sv
// Bus bundle between the CPU/data-memory side and dm_access_ctrl.
// master = CPU request side plus data-memory model; slave = the controller.
interface dm_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        Men_Write;
    logic [5:0]  DM_Addr;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, M_R_Data,
        input  req_ready, resp_valid, resp_rdata, resp_err, Men_Write, DM_Addr, M_W_Data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, M_R_Data,
        output req_ready, resp_valid, resp_rdata, resp_err, Men_Write, DM_Addr, M_W_Data
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Byte/halfword/word load-store controller in front of a synchronous word-wide data memory.
// Optional alignment checking is enabled by defining DM_CTRL_ALIGN_CHK_EN.
module dm_access_ctrl (
    input  logic              clk_dm,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        men_write_q;
    logic [5:0]  dm_addr_q;
    logic [31:0] m_w_data_q;

    logic        mis_d;
    logic [31:0] byte_sh_d;
    logic [31:0] half_sh_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mis_d = 1'b0;
`ifdef DM_CTRL_ALIGN_CHK_EN
        if (bus.req_size == 2'b01) begin
            mis_d = bus.req_addr[0];
        end else if (bus.req_size[1]) begin
            mis_d = |bus.req_addr[1:0];
        end
`endif
    end

    // Lane extraction and merge work on the word returned for the latched address.
    always_comb begin
        byte_sh_d = bus.M_R_Data >> {lane_q, 3'b000};
        half_sh_d = bus.M_R_Data >> {lane_q[1], 4'b0000};
        load_d    = bus.M_R_Data;
        merge_d   = bus.M_R_Data;
        unique case (size_q)
            2'b00:   load_d = uns_q ? {24'b0, byte_sh_d[7:0]}
                                    : {{24{byte_sh_d[7]}}, byte_sh_d[7:0]};
            2'b01:   load_d = uns_q ? {16'b0, half_sh_d[15:0]}
                                    : {{16{half_sh_d[15]}}, half_sh_d[15:0]};
            default: load_d = bus.M_R_Data;
        endcase
        if (size_q[0]) begin
            merge_d = (bus.M_R_Data & ~(32'h0000_FFFF << {lane_q[1], 4'b0000}))
                    | ({16'b0, wdata_q} << {lane_q[1], 4'b0000});
        end else begin
            merge_d = (bus.M_R_Data & ~(32'h0000_00FF << {lane_q, 3'b000}))
                    | ({24'b0, wdata_q[7:0]} << {lane_q, 3'b000});
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched request fields are reset too, keeping the datapath free of X after reset.
            state_q      <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 16'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            men_write_q  <= 1'b0;
            dm_addr_q    <= 6'b0;
            m_w_data_q   <= 32'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q         <= bus.req_we;
                        uns_q        <= bus.req_unsigned;
                        size_q       <= bus.req_size;
                        lane_q       <= bus.req_addr[1:0];
                        wdata_q      <= bus.req_wdata[15:0];
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= 32'b0;
                        resp_err_q   <= mis_d;
                        if (mis_d) begin
                            // Misaligned: no memory cycle at all, answer straight away.
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (bus.req_we && bus.req_size[1]) begin
                            dm_addr_q   <= bus.req_addr[7:2];
                            m_w_data_q  <= bus.req_wdata;
                            men_write_q <= 1'b1;
                            state_q     <= WR;
                        end else begin
                            dm_addr_q <= bus.req_addr[7:2];
                            state_q   <= RD;
                        end
                    end
                end
                RD: begin
                    state_q <= CAP;
                end
                CAP: begin
                    if (we_q) begin
                        m_w_data_q  <= merge_d;
                        men_write_q <= 1'b1;
                        state_q     <= WR;
                    end else begin
                        resp_rdata_q <= load_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WR: begin
                    men_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    men_write_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.Men_Write  = men_write_q;
    assign bus.DM_Addr    = dm_addr_q;
    assign bus.M_W_Data   = m_w_data_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: latency/outcome model plus a synchronous memory.
// Builds with or without DM_CTRL_ALIGN_CHK_EN.
module tb_dm_access_ctrl;

    logic clk_dm = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_dm = ~clk_dm;

    dm_access_ctrl_if bus();

    dm_access_ctrl dut (
        .clk_dm (clk_dm),
        .rst_n  (rst_n),
        .bus    (bus)
    );

`ifdef DM_CTRL_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Data memory: one-cycle read latency, write on the edge that ends the Men_Write cycle.
    logic [31:0] mem [64];
    always @(posedge clk_dm) begin
        if (bus.Men_Write) mem[bus.DM_Addr] <= bus.M_W_Data;
        bus.M_R_Data <= mem[bus.DM_Addr];
    end

    // Transaction model: outcome and latency computed from the access rules.
    logic [31:0] exp_mem [64];
    bit          m_busy, m_store, m_err, m_acc;
    int          m_cnt, m_lat, m_sh;
    logic [31:0] m_rdata, m_wdata, m_w, m_v;
    logic [5:0]  m_idx;

    int          cyc = 0, acc_cyc = 0, last_lat = 0, we_cnt = 0, rsp_cnt = 0;
    logic [5:0]  last_we_addr;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [31:0] rsp_q [$];
    bit          chk_en = 1'b0;

    always @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_acc  = 1'b0;
        end else begin
            cyc++;
            m_acc = 1'b0;
            if (bus.resp_valid) begin
                last_lat   = cyc - acc_cyc;
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
                rsp_cnt++;
                rsp_q.push_back(bus.resp_rdata);
            end
            if (bus.Men_Write) begin
                we_cnt++;
                last_we_addr = bus.DM_Addr;
            end
            if (m_busy) begin
                m_cnt++;
                if (m_store && !m_err && m_cnt == m_lat - 1) exp_mem[m_idx] = m_wdata;
                if (m_cnt == m_lat) m_busy = 1'b0;
            end else if (bus.req_valid) begin
                m_idx   = bus.req_addr[7:2];
                m_w     = exp_mem[m_idx];
                m_store = bus.req_we;
                m_err   = ALIGN_CHK && ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
                                        (bus.req_size[1] && bus.req_addr[1:0] != 2'b00));
                if (m_err)                  m_lat = 1;
                else if (!m_store)          m_lat = 3;
                else if (bus.req_size[1])   m_lat = 2;
                else                        m_lat = 4;
                if (bus.req_size == 2'b00) begin
                    m_sh = 8 * int'(bus.req_addr[1:0]);
                    m_v  = (m_w >> m_sh) & 32'hFF;
                    if (!bus.req_unsigned && m_v[7]) m_v = m_v | 32'hFFFF_FF00;
                    m_wdata = (m_w & ~(32'hFF << m_sh)) | ((bus.req_wdata & 32'hFF) << m_sh);
                end else if (bus.req_size == 2'b01) begin
                    m_sh = 16 * int'(bus.req_addr[1]);
                    m_v  = (m_w >> m_sh) & 32'hFFFF;
                    if (!bus.req_unsigned && m_v[15]) m_v = m_v | 32'hFFFF_0000;
                    m_wdata = (m_w & ~(32'hFFFF << m_sh)) | ((bus.req_wdata & 32'hFFFF) << m_sh);
                end else begin
                    m_v     = m_w;
                    m_wdata = bus.req_wdata;
                end
                m_rdata = (m_err || m_store) ? 32'h0 : m_v;
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_acc   = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    // Per-cycle comparison of every registered output against the model.
    logic exp_v, exp_w;
    always @(negedge clk_dm) begin
        if (rst_n && chk_en) begin
            exp_v = m_busy && (m_cnt == m_lat - 1);
            exp_w = m_busy && m_store && !m_err && (m_cnt == m_lat - 2);
            check("req_ready", bus.req_ready, !m_busy);
            check("resp_valid", bus.resp_valid, exp_v);
            check("Men_Write", bus.Men_Write, exp_w);
            if (exp_v) begin
                check("resp_rdata", bus.resp_rdata, m_rdata);
                check("resp_err", bus.resp_err, m_err);
            end
            if (exp_w) begin
                check("DM_Addr", bus.DM_Addr, m_idx);
                check("M_W_Data", bus.M_W_Data, m_wdata);
            end
        end
    end

    task automatic wait_acc();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk_dm);
            #1;
            got = m_acc;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance, expected one within 20 cycles");
        end
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk_dm);
            #1;
            done = !m_busy;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got busy, expected idle within 20 cycles");
        end
    endtask

    task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [7:0] a, input logic [31:0] wd);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    // One request; fields are scrambled after acceptance to show they were latched.
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [7:0] a, input logic [31:0] wd);
        @(negedge clk_dm);
        drive(we, sz, uns, a, wd);
        bus.req_valid = 1'b1;
        wait_acc();
        bus.req_valid = 1'b0;
        drive(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
    endtask

    task automatic backdoor(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        exp_mem[idx] = val;
    endtask

    int          w0, r0;
    logic [31:0] old8;

    initial begin
        bus.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 64; i++) backdoor(i, 32'h1000_0000 + i);

        repeat (2) @(posedge clk_dm);
        #1;
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_Men_Write", bus.Men_Write, 1'b0);
        check("rst_DM_Addr", bus.DM_Addr, 6'd0);
        check("rst_M_W_Data", bus.M_W_Data, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_err", bus.resp_err, 1'b0);
        @(negedge clk_dm);
        rst_n = 1'b1;
        @(posedge clk_dm);
        #1;
        check("ready_after_reset", bus.req_ready, 1'b1);
        chk_en = 1'b1;

        // Word store then load.
        w0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);
        wait_done();
        check("wst_pulses", 32'(we_cnt - w0), 32'd1);
        check("wst_addr", last_we_addr, 6'd4);
        check("wst_latency", 32'(last_lat), 32'd2);
        check("wst_mem", mem[4], 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        wait_done();
        check("wld_rdata", last_rdata, 32'hDEADBEEF);
        check("wld_latency", 32'(last_lat), 32'd3);

        // Byte / half extension.
        backdoor(4, 32'h80FF7F01);
        issue(1'b0, 2'b00, 1'b0, 8'h13, 32'h0);
        wait_done();
        check("ldb_signed", last_rdata, 32'hFFFFFF80);
        issue(1'b0, 2'b00, 1'b1, 8'h13, 32'h0);
        wait_done();
        check("ldb_unsigned", last_rdata, 32'h00000080);
        issue(1'b0, 2'b00, 1'b0, 8'h11, 32'h0);
        wait_done();
        issue(1'b0, 2'b01, 1'b0, 8'h12, 32'h0);
        wait_done();
        check("ldh_signed_hi", last_rdata, 32'hFFFF80FF);

        // Sub-word merge.
        backdoor(4, 32'h11223344);
        w0 = we_cnt;
        issue(1'b1, 2'b01, 1'b0, 8'h12, 32'h5555ABCD);
        wait_done();
        check("sth_mem", mem[4], 32'hABCD3344);
        check("sth_latency", 32'(last_lat), 32'd4);
        check("sth_pulses", 32'(we_cnt - w0), 32'd1);
        issue(1'b1, 2'b00, 1'b0, 8'h21, 32'h123456EE);
        wait_done();
        check("stb_mem", mem[8], 32'h1000EE08);

        // Misaligned word load.
        w0 = we_cnt;
        issue(1'b0, 2'b10, 1'b0, 8'h11, 32'h0);
        wait_done();
`ifdef DM_CTRL_ALIGN_CHK_EN
        check("mis_err", last_err, 1'b1);
        check("mis_latency", 32'(last_lat), 32'd1);
        check("mis_rdata", last_rdata, 32'h0);
        check("mis_no_write", 32'(we_cnt - w0), 32'd0);
`else
        check("mis_err", last_err, 1'b0);
        check("mis_latency", 32'(last_lat), 32'd3);
        check("mis_rdata", last_rdata, 32'hABCD3344);
`endif
        issue(1'b0, 2'b01, 1'b1, 8'h13, 32'h0);
        wait_done();
        issue(1'b1, 2'b01, 1'b0, 8'h31, 32'h0000BEEF);
        wait_done();

        // Reset during WR of a byte store.
        old8 = mem[8];
        r0   = rsp_cnt;
        issue(1'b1, 2'b00, 1'b0, 8'h22, 32'h00000077);
        @(posedge clk_dm);
        @(posedge clk_dm);
        #2;
        check("abort_in_wr", bus.Men_Write, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_we_drop", bus.Men_Write, 1'b0);
        check("abort_addr_clr", bus.DM_Addr, 6'd0);
        check("abort_valid", bus.resp_valid, 1'b0);
        repeat (2) @(posedge clk_dm);
        #1;
        check("abort_mem", mem[8], old8);
        @(negedge clk_dm);
        rst_n = 1'b1;
        @(posedge clk_dm);
        #1;
        check("abort_ready", bus.req_ready, 1'b1);
        check("abort_no_resp", 32'(rsp_cnt - r0), 32'd0);

        // Back-to-back loads with req_valid held high.
        rsp_q.delete();
        @(negedge clk_dm);
        drive(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        bus.req_valid = 1'b1;
        wait_acc();
        drive(1'b0, 2'b01, 1'b0, 8'h20, 32'h0);
        wait_acc();
        drive(1'b0, 2'b00, 1'b1, 8'h13, 32'h0);
        wait_acc();
        bus.req_valid = 1'b0;
        wait_done();
        check("b2b_count", rsp_q.size(), 32'd3);
        if (rsp_q.size() == 3) begin
            check("b2b_rsp0", rsp_q[0], 32'hABCD3344);
            check("b2b_rsp1", rsp_q[1], 32'hFFFFEE08);
            check("b2b_rsp2", rsp_q[2], 32'h000000AB);
        end

        repeat (2) @(posedge clk_dm);
        #1;
        for (int i = 0; i < 64; i++) check($sformatf("mem_final[%0d]", i), mem[i], exp_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
